// File: rtl/y_bitstream_rx.sv
// y_bitstream_rx
// Receive-side serializer for the Y-channel encoder. Encoder words (full
// 32-bit words, a block's final partial word, or a bare end-of-block flag)
// are queued in a small FIFO and emitted MSB-first as bytes on a
// valid/ready interface. The final byte of a partial word is padded with
// 1-bits, and a block_done pulse follows the last byte of each block.
//
// Optional feature macro: STUFF_EN
//   defined   - every emitted 0xFF byte is followed by an inserted 0x00
//   undefined - 0xFF passes through unmodified (no STUFF state)

module y_bitstream_rx #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [31:0]                   JPEG_bitstream,
    input  logic                          data_ready,
    input  logic [4:0]                    y_orc,
    input  logic                          end_of_block_output,
    input  logic                          end_of_block_empty,
    output logic [7:0]                    byte_out,
    output logic                          byte_valid,
    input  logic                          byte_ready,
    output logic                          block_done,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    // One queued unit of work: data bits, how many of them are valid
    // (32 full word, 1..31 partial word, 0 bare end-of-block) and whether
    // it closes a block.
    typedef struct packed {
        logic [31:0] data;
        logic [5:0]  cnt;
        logic        eob;
    } entry_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_EMIT
`ifdef STUFF_EN
        , ST_STUFF
`endif
    } state_t;

    // Force every bit below the valid count to 1 so the final byte of a
    // partial word comes out padded; bytes past ceil(cnt/8) are never sent.
    function automatic logic [31:0] pad_word(input logic [31:0] d, input logic [5:0] c);
        logic [31:0] mask;
        if (c >= 6'd32) mask = '0;
        else            mask = 32'hFFFF_FFFF >> c;
        return d | mask;
    endfunction

    // ------------------------------------------------------------------
    // FIFO storage and bookkeeping
    // ------------------------------------------------------------------
    entry_t          mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_addr1;

    entry_t          wr_entry0;
    entry_t          wr_entry1;
    entry_t          head;
    logic [31:0]     head_pad;
    logic [2:0]      head_bytes;

    logic            req0;
    logic            req1;
    logic            acc0;
    logic            acc1;
    logic            drop;
    logic            pop;
    logic [LW:0]     free_slots;
    logic            fifo_nonempty;

    // ------------------------------------------------------------------
    // Serializer state
    // ------------------------------------------------------------------
    state_t          state;
    logic [31:0]     sh_data;
    logic [2:0]      bytes_left;
    logic            sh_eob;

    logic            xfer;
    logic            stuff_hit;
    logic            last;
    logic            fold;

    // Build the two candidate write entries and the head-of-queue view.
    always_comb begin
        wr_entry0.data = JPEG_bitstream;
        wr_entry0.cnt  = 6'd32;
        wr_entry0.eob  = 1'b0;

        // A partial word takes priority over a bare end-of-block flag.
        if (end_of_block_output) begin
            wr_entry1.data = JPEG_bitstream;
            wr_entry1.cnt  = {1'b0, y_orc};
        end else begin
            wr_entry1.data = '0;
            wr_entry1.cnt  = '0;
        end
        wr_entry1.eob = 1'b1;

        head       = mem[rd_ptr];
        head_pad   = pad_word(head.data, head.cnt);
        head_bytes = 3'((head.cnt + 6'd7) >> 3);
    end

    assign fifo_nonempty = (fifo_level != '0);
    assign xfer          = byte_valid && byte_ready;
    assign last          = (bytes_left == 3'd1);

`ifdef STUFF_EN
    assign stuff_hit = (state == ST_EMIT) && (byte_out == 8'hFF);
`else
    assign stuff_hit = 1'b0;
`endif

    // The last accepted byte of an entry loads the next one directly when
    // it has bytes to send, so back-to-back words run without a bubble.
    // Bare end-of-block entries still go through LOAD so their block_done
    // pulse never merges with the previous entry's pulse.
    assign fold = xfer && !stuff_hit && last && fifo_nonempty && (head.cnt != 6'd0);
    assign pop  = fifo_nonempty && ((state == ST_LOAD) || fold);

    // A pop in the same cycle frees a slot, so writing at full with a
    // concurrent pop is not an overflow. The full word lands before the
    // partial entry; whichever has no slot is dropped.
    assign req0       = data_ready;
    assign req1       = end_of_block_output || end_of_block_empty;
    assign free_slots = (LW+1)'(FIFO_DEPTH) - {1'b0, fifo_level} + (LW+1)'(pop);
    assign acc0       = req0 && (free_slots != '0);
    assign acc1       = req1 && (free_slots > (LW+1)'(acc0));
    assign drop       = (req0 && !acc0) || (req1 && !acc1);
    assign wr_addr1   = wr_ptr + AW'(acc0);

    // Entry storage writes.
    // NOTE: the storage array has no reset; the pointers and level alone
    // decide which slots hold live data, so clearing the array buys nothing.
    always_ff @(posedge clk) begin
        if (acc0) mem[wr_ptr]   <= wr_entry0;
        if (acc1) mem[wr_addr1] <= wr_entry1;
    end

    // Pointer, occupancy and sticky overflow tracking.
    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr + AW'(acc0) + AW'(acc1);
            rd_ptr     <= rd_ptr + AW'(pop);
            fifo_level <= fifo_level + LW'(acc0) + LW'(acc1) - LW'(pop);
            if (drop) overflow <= 1'b1;
        end
    end

    // Serializer FSM with registered byte_out/byte_valid/block_done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            sh_data    <= '0;
            bytes_left <= '0;
            sh_eob     <= 1'b0;
            byte_out   <= 8'h00;
            byte_valid <= 1'b0;
            block_done <= 1'b0;
        end else begin
            block_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (fifo_nonempty) state <= ST_LOAD;
                end

                ST_LOAD: begin
                    if (head_bytes == 3'd0) begin
                        // Bare end-of-block: nothing to send, just signal.
                        block_done <= head.eob;
                        state      <= ST_IDLE;
                    end else begin
                        sh_data    <= head_pad;
                        byte_out   <= head_pad[31:24];
                        bytes_left <= head_bytes;
                        sh_eob     <= head.eob;
                        byte_valid <= 1'b1;
                        state      <= ST_EMIT;
                    end
                end

`ifdef STUFF_EN
                ST_EMIT, ST_STUFF: begin
`else
                ST_EMIT: begin
`endif
                    if (xfer) begin
`ifdef STUFF_EN
                        if (stuff_hit) begin
                            byte_out <= 8'h00;
                            state    <= ST_STUFF;
                        end else
`endif
                        if (!last) begin
                            sh_data    <= sh_data << 8;
                            byte_out   <= sh_data[23:16];
                            bytes_left <= bytes_left - 3'd1;
                            state      <= ST_EMIT;
                        end else begin
                            block_done <= sh_eob;
                            if (fold) begin
                                sh_data    <= head_pad;
                                byte_out   <= head_pad[31:24];
                                bytes_left <= head_bytes;
                                sh_eob     <= head.eob;
                                state      <= ST_EMIT;
                            end else if (fifo_nonempty) begin
                                byte_valid <= 1'b0;
                                state      <= ST_LOAD;
                            end else begin
                                byte_valid <= 1'b0;
                                state      <= ST_IDLE;
                            end
                        end
                    end
                end

                default: begin
                    byte_valid <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
